m68k_bus_arbiter: RTL and testbench

M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

---
 rtl/m68k_bus_arbiter_if.sv | 51 +++++
 rtl/m68k_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_m68k_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_arbiter_if.sv
// m68k_bus_arbiter_if
// Bundles the 68000 bus-arbitration handshake (BR/BG/BGACK), the bus clock
// and the sequencer-side grant/ownership signals between the arbiter and
// the rest of the system.
//   M68K_CLK      68000 bus clock, asynchronous to the arbiter clock
//   M68K_BR_n     external bus request (active low)
//   M68K_BGACK_n  external grant acknowledge (active low)
//   M68K_BG_n     bus grant to the external master (active low)
//   seq_busy      local bus sequencer is mid-cycle
//   cnt_clr       single-cycle pulse clearing ext_cnt
//   cpu_grant     sequencer may start a new bus cycle
//   ext_owned     external master currently owns the bus
//   ext_cnt       saturating count of completed external tenures
// Modport master is the arbiter side, slave is the system side.
interface m68k_bus_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             M68K_CLK;
  logic             M68K_BR_n;
  logic             M68K_BGACK_n;
  logic             M68K_BG_n;
  logic             seq_busy;
  logic             cnt_clr;
  logic             cpu_grant;
  logic             ext_owned;
  logic [CNT_W-1:0] ext_cnt;

  modport master (
    input  M68K_CLK,
    input  M68K_BR_n,
    input  M68K_BGACK_n,
    input  seq_busy,
    input  cnt_clr,
    output M68K_BG_n,
    output cpu_grant,
    output ext_owned,
    output ext_cnt
  );

  modport slave (
    output M68K_CLK,
    output M68K_BR_n,
    output M68K_BGACK_n,
    output seq_busy,
    output cnt_clr,
    input  M68K_BG_n,
    input  cpu_grant,
    input  ext_owned,
    input  ext_cnt
  );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// m68k_bus_arbiter
// 68000-style bus arbiter running on the fast PI_CLK. The 68000 bus clock
// and the BR_n/BGACK_n handshake are synchronised as data; every state and
// BG_n change happens only in the PI_CLK cycle that sees a synced falling
// edge of M68K_CLK (c7m_fall), so BG_n moves in step with the 68000 bus.
// Ports:
//   PI_CLK   sole clock, all state updates on its rising edge
//   RESET_n  asynchronous active-low reset
//   bus      arbitration interface (master modport), see m68k_bus_arbiter_if
// Parameters:
//   GRANT_TIMEOUT  c7m_fall edges BG_n may stay low without BGACK_n
//   CNT_W          width of the external-tenure counter
module m68k_bus_arbiter #(
  parameter int GRANT_TIMEOUT = 8,
  parameter int CNT_W         = 16
) (
  input logic                 PI_CLK,
  input logic                 RESET_n,
  m68k_bus_arbiter_if.master  bus
);

  localparam logic [1:0] OWN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;
  localparam logic [1:0] EXT   = 2'd3;

  localparam int            TW     = $clog2(GRANT_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(GRANT_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             c7m_p0, c7m_p1, c7m_p2;
  logic             br_p0, br_p1;
  logic             bgack_p0, bgack_p1;
  logic             c7m_fall;
  logic [1:0]       state, state_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;
  logic             ext_exit;
  logic             bg_n_r, cpu_grant_r, ext_owned_r;
  logic [CNT_W-1:0] ext_cnt_r;

  // Synchronizer stages: _p0 metastability flop, _p1 synced value,
  // c7m_p2 holds the previous synced bus clock for edge detection.
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      c7m_p0   <= 1'b0;
      c7m_p1   <= 1'b0;
      c7m_p2   <= 1'b0;
      br_p0    <= 1'b1;
      br_p1    <= 1'b1;
      bgack_p0 <= 1'b1;
      bgack_p1 <= 1'b1;
    end else begin
      c7m_p0   <= bus.M68K_CLK;
      c7m_p1   <= c7m_p0;
      c7m_p2   <= c7m_p1;
      br_p0    <= bus.M68K_BR_n;
      br_p1    <= br_p0;
      bgack_p0 <= bus.M68K_BGACK_n;
      bgack_p1 <= bgack_p0;
    end
  end

  assign c7m_fall = c7m_p2 & ~c7m_p1;

  // Arbitration decisions, taken only on a bus-clock falling edge.
  // An asserted BGACK_n always wins: it either completes a grant or is an
  // unsolicited takeover from OWN/DRAIN.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    ext_exit  = 1'b0;
    if (c7m_fall) begin
      case (state)
        OWN: begin
          if (!bgack_p1)   state_nxt = EXT;
          else if (!br_p1) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (!bgack_p1)      state_nxt = EXT;
          else if (!bus.seq_busy) state_nxt = br_p1 ? OWN : GRANT;
        end
        GRANT: begin
          if (!bgack_p1)           state_nxt = EXT;
          else if (br_p1)          state_nxt = OWN;
          else if (tcnt == T_LAST) state_nxt = OWN;
          else                     tcnt_nxt  = tcnt + TW'(1);
        end
        EXT: begin
          if (bgack_p1) begin
            ext_exit  = 1'b1;
            // A request already pending goes straight back to GRANT; the
            // local sequencer cannot have started anything while we were out.
            state_nxt = br_p1 ? OWN : GRANT;
          end
        end
        default: state_nxt = OWN;
      endcase
      if (state_nxt == GRANT && state != GRANT) tcnt_nxt = '0;
    end
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= OWN;
      tcnt        <= '0;
      bg_n_r      <= 1'b1;
      cpu_grant_r <= 1'b1;
      ext_owned_r <= 1'b0;
      ext_cnt_r   <= '0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      bg_n_r      <= (state_nxt != GRANT);
      cpu_grant_r <= (state_nxt == OWN);
      ext_owned_r <= (state_nxt == EXT);
      if (bus.cnt_clr)   ext_cnt_r <= '0;
      else if (ext_exit) ext_cnt_r <= sat_inc(ext_cnt_r);
    end
  end

  // cpu_grant drops as soon as the synced request is seen in OWN, without
  // waiting for the bus-clock edge, so no new sequencer cycle can start.
  assign bus.cpu_grant = cpu_grant_r & ~((state == OWN) & ~br_p1);
  assign bus.M68K_BG_n = bg_n_r;
  assign bus.ext_owned = ext_owned_r;
  assign bus.ext_cnt   = ext_cnt_r;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// tb_m68k_bus_arbiter
// Directed stimulus for the 68000 bus arbiter with a behavioural model of
// the arbitration rules, compared against the DUT every PI_CLK cycle, plus
// hand-computed literal expectations at key points of each scenario.
module tb_m68k_bus_arbiter;
  localparam int GT    = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  localparam int M_OWN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_GRANT = 2;
  localparam int M_EXT   = 3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  m68k_bus_arbiter_if #(.CNT_W(CW)) bus();

  m68k_bus_arbiter #(.GRANT_TIMEOUT(GT), .CNT_W(CW)) dut (
    .PI_CLK (clk),
    .RESET_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 68000 bus clock: 8 PI_CLK periods, changes away from the PI_CLK edge.
  initial begin
    bus.M68K_CLK = 1'b0;
    forever begin
      repeat (4) @(posedge clk);
      #2 bus.M68K_CLK = ~bus.M68K_CLK;
    end
  end

  // ---------------- behavioural model ----------------
  // Inputs reach the arbiter two PI_CLK samples late; a bus-clock fall is
  // recognised when the delayed clock history shows 1 then 0.
  int   m_mode;
  int   m_grant_falls;
  int   m_cnt;
  logic h_clk [3];
  logic h_br  [2];
  logic h_ack [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_OWN; m_grant_falls = 0; m_cnt = 0;
      h_clk[0] = 0; h_clk[1] = 0; h_clk[2] = 0;
      h_br[0] = 1;  h_br[1] = 1;
      h_ack[0] = 1; h_ack[1] = 1;
    end else begin
      logic fall, br_seen, ack_seen, exit_now;
      fall     = h_clk[2] && !h_clk[1];
      br_seen  = !h_br[1];
      ack_seen = !h_ack[1];
      exit_now = 0;
      if (fall) begin
        if (m_mode == M_EXT) begin
          if (!ack_seen) begin
            exit_now = 1;
            m_mode = br_seen ? M_GRANT : M_OWN;
            m_grant_falls = 0;
          end
        end else if (ack_seen) begin
          m_mode = M_EXT;
        end else if (m_mode == M_OWN) begin
          if (br_seen) m_mode = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
          if (!bus.seq_busy) begin
            m_mode = br_seen ? M_GRANT : M_OWN;
            m_grant_falls = 0;
          end
        end else begin
          m_grant_falls++;
          if (!br_seen || m_grant_falls == GT) m_mode = M_OWN;
        end
      end
      if (bus.cnt_clr) m_cnt = 0;
      else if (exit_now && m_cnt < CMAX) m_cnt++;
      h_clk[2] = h_clk[1]; h_clk[1] = h_clk[0]; h_clk[0] = bus.M68K_CLK;
      h_br[1]  = h_br[0];  h_br[0]  = bus.M68K_BR_n;
      h_ack[1] = h_ack[0]; h_ack[0] = bus.M68K_BGACK_n;
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      logic e_bg, e_cg, e_eo;
      e_bg = (m_mode != M_GRANT);
      e_eo = (m_mode == M_EXT);
      e_cg = (m_mode == M_OWN) && h_br[1];
      checks++;
      if (bus.M68K_BG_n === e_bg && bus.cpu_grant === e_cg &&
          bus.ext_owned === e_eo && int'(bus.ext_cnt) == m_cnt)
        passed++;
      else
        $display("FAIL model t=%0t bg_n=%b want %b cpu_grant=%b want %b ext_owned=%b want %b ext_cnt=%0d want %0d",
                 $time, bus.M68K_BG_n, e_bg, bus.cpu_grant, e_cg,
                 bus.ext_owned, e_eo, bus.ext_cnt, m_cnt);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_bg(input string name, input logic v, input int maxc);
    int n = 0;
    while (bus.M68K_BG_n !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.M68K_BG_n), int'(v));
    tick(1);
  endtask

  task automatic wait_ext(input string name, input logic v, input int maxc);
    int n = 0;
    while (bus.ext_owned !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.ext_owned), int'(v));
    tick(1);
  endtask

  task automatic tenure();
    wait_bg("ten_grant", 1'b0, 40);
    bus.M68K_BGACK_n = 1'b0;
    wait_ext("ten_ext", 1'b1, 24);
    bus.M68K_BGACK_n = 1'b1;
    wait_ext("ten_exit", 1'b0, 24);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int falls, n;
    logic prev;
    rst_n = 1'b0;
    bus.M68K_BR_n = 1'b1;
    bus.M68K_BGACK_n = 1'b1;
    bus.seq_busy = 1'b0;
    bus.cnt_clr = 1'b0;
    tick(3);
    check("rst_bg_n", int'(bus.M68K_BG_n), 1);
    check("rst_cpu_grant", int'(bus.cpu_grant), 1);
    check("rst_ext_owned", int'(bus.ext_owned), 0);
    check("rst_ext_cnt", int'(bus.ext_cnt), 0);
    rst_n = 1'b1;
    tick(20);

    // Idle bus request, acknowledge, release.
    bus.M68K_BR_n = 1'b0;
    tick(3);
    check("req_cpu_grant_drop", int'(bus.cpu_grant), 0);
    wait_bg("req_bg_low", 1'b0, 24);
    bus.M68K_BGACK_n = 1'b0;
    wait_ext("ack_ext_owned", 1'b1, 24);
    check("ack_bg_high", int'(bus.M68K_BG_n), 1);
    bus.M68K_BR_n = 1'b1;
    bus.M68K_BGACK_n = 1'b1;
    wait_ext("rel_ext_owned", 1'b0, 24);
    tick(2);
    check("rel_ext_cnt", int'(bus.ext_cnt), 1);
    check("rel_cpu_grant", int'(bus.cpu_grant), 1);

    // Sequencer busy holds off the grant; then withdrawal in GRANT.
    tick(8);
    bus.seq_busy = 1'b1;
    bus.M68K_BR_n = 1'b0;
    tick(40);
    check("busy_bg_high", int'(bus.M68K_BG_n), 1);
    check("busy_cpu_grant", int'(bus.cpu_grant), 0);
    bus.seq_busy = 1'b0;
    wait_bg("busy_done_bg_low", 1'b0, 24);
    bus.M68K_BR_n = 1'b1;
    wait_bg("withdraw_bg_high", 1'b1, 24);
    check("withdraw_ext_cnt", int'(bus.ext_cnt), 1);
    tick(16);

    // Grant timeout with BR_n held and no acknowledge.
    bus.M68K_BR_n = 1'b0;
    wait_bg("to_bg_low", 1'b0, 40);
    falls = 0; n = 0; prev = bus.M68K_CLK;
    while (bus.M68K_BG_n == 1'b0 && n < 150) begin
      @(negedge clk);
      if (prev && !bus.M68K_CLK) falls++;
      prev = bus.M68K_CLK;
      n++;
    end
    check("to_falls", falls, GT);
    check("to_ext_cnt", int'(bus.ext_cnt), 1);
    wait_bg("to_regrant", 1'b0, 40);
    bus.M68K_BR_n = 1'b1;
    wait_bg("to_release", 1'b1, 24);
    tick(16);

    // Back-to-back tenures, clear coincident with the third exit.
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    check("clr_ext_cnt", int'(bus.ext_cnt), 0);
    bus.M68K_BR_n = 1'b0;
    tenure();
    check("b2b1_regrant", int'(bus.M68K_BG_n), 0);
    tenure();
    check("b2b2_regrant", int'(bus.M68K_BG_n), 0);
    check("b2b_ext_cnt", int'(bus.ext_cnt), 2);
    wait_bg("b2b3_grant", 1'b0, 40);
    bus.M68K_BGACK_n = 1'b0;
    wait_ext("b2b3_ext", 1'b1, 24);
    bus.M68K_BR_n = 1'b1;
    bus.cnt_clr = 1'b1;
    bus.M68K_BGACK_n = 1'b1;
    wait_ext("b2b3_exit", 1'b0, 24);
    bus.cnt_clr = 1'b0;
    check("b2b_clr_cnt", int'(bus.ext_cnt), 0);
    tick(16);

    // Saturation, then reset in the middle of a tenure.
    bus.M68K_BR_n = 1'b0;
    for (int i = 0; i < CMAX + 1; i++) tenure();
    check("sat_ext_cnt", int'(bus.ext_cnt), CMAX);
    wait_bg("sat_grant", 1'b0, 40);
    bus.M68K_BGACK_n = 1'b0;
    wait_ext("sat_ext", 1'b1, 24);
    bus.M68K_BR_n = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("arst_bg_n", int'(bus.M68K_BG_n), 1);
    check("arst_ext_owned", int'(bus.ext_owned), 0);
    check("arst_ext_cnt", int'(bus.ext_cnt), 0);
    tick(3);
    rst_n = 1'b1;
    wait_ext("takeover_ext", 1'b1, 40);
    check("takeover_bg_n", int'(bus.M68K_BG_n), 1);
    bus.M68K_BGACK_n = 1'b1;
    wait_ext("takeover_exit", 1'b0, 40);
    check("takeover_cnt", int'(bus.ext_cnt), 1);
    tick(16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
